// File: rtl/sprom_pkg.sv
// rtl/sprom_pkg.sv - shared types and defaults for the sequential ROM reader (SPROM_PREFETCH_EN adds PREFETCH)
package sprom_pkg;

    localparam int ACCESS_CYCLES_DEF = 3;
    localparam int ADDR_W_DEF        = 17;
    localparam int CTR_W             = 4;

    typedef logic [15:0] word_t;

`ifdef SPROM_PREFETCH_EN
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_SAMPLE   = 2'd2,
        ST_PREFETCH = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_SAMPLE = 2'd2
    } state_t;
`endif

endpackage

// File: rtl/sprom_wait_ctr.sv
// rtl/sprom_wait_ctr.sv - loadable down-counter with zero flag, pacing ROM access time
module sprom_wait_ctr
    import sprom_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [CTR_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CTR_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sprom_reader.sv
// rtl/sprom_reader.sv - request/ack reader for an asynchronous 16-bit ROM; SPROM_PREFETCH_EN adds a one-entry sequential prefetch
module sprom_reader
    import sprom_pkg::*;
#(
    parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF,
    parameter int ADDR_W        = ADDR_W_DEF
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic              REQ,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    output logic              ACK,
    output word_t             DATA,
    output logic              BUSY,
    output logic [ADDR_W-1:0] ROM_ADDR,
    output logic              ROM_nOE,
    input  word_t             ROM_DATA
);

    if ((ACCESS_CYCLES < 1) || (ACCESS_CYCLES > 15)) begin : g_bad_access_cycles
        $error("sprom_reader: ACCESS_CYCLES must be within 1..15");
    end

    // Demand sampling happens one edge after the counter reaches zero (in SAMPLE);
    // prefetch samples inside PREFETCH, so it loads one more to keep the same timing.
    localparam logic [CTR_W-1:0] LOAD_DEMAND = CTR_W'(ACCESS_CYCLES - 1);
`ifdef SPROM_PREFETCH_EN
    localparam logic [CTR_W-1:0] LOAD_PF     = CTR_W'(ACCESS_CYCLES);
`endif

    state_t           state;
    logic             req_take;
    logic             start_demand;
    logic             ctr_load;
    logic             ctr_dec;
    logic             ctr_zero;
    logic [CTR_W-1:0] ctr_val;

    // A request is never taken in the ACK cycle: the requester's drop is still pending.
    assign req_take = (state == ST_IDLE) && !ACK && REQ;

`ifdef SPROM_PREFETCH_EN
    word_t             buf_data;
    logic [ADDR_W-1:0] buf_addr;
    logic              buf_valid;
    logic              pf_pend;
    logic              hit_q;
    logic              hit;
    logic              start_pf;

    assign hit          = req_take && buf_valid && (REQ_ADDR == buf_addr);
    assign start_pf     = (state == ST_IDLE) && !ACK && !REQ && pf_pend;
    assign start_demand = req_take && !hit;
`else
    assign start_demand = req_take;
`endif

    always_comb begin
        ctr_load = start_demand;
        ctr_val  = LOAD_DEMAND;
        ctr_dec  = (state == ST_ACCESS);
`ifdef SPROM_PREFETCH_EN
        if (start_pf) begin
            ctr_load = 1'b1;
            ctr_val  = LOAD_PF;
        end
        if (state == ST_PREFETCH) begin
            ctr_dec = 1'b1;
        end
`endif
    end

    sprom_wait_ctr u_wait_ctr (
        .clk      (CLK),
        .resetn   (nRESET),
        .load     (ctr_load),
        .load_val (ctr_val),
        .dec      (ctr_dec),
        .zero     (ctr_zero)
    );

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state    <= ST_IDLE;
            ACK      <= 1'b0;
            BUSY     <= 1'b0;
            ROM_nOE  <= 1'b1;
            ROM_ADDR <= '0;
            DATA     <= '0;
`ifdef SPROM_PREFETCH_EN
            buf_data  <= '0;
            buf_addr  <= '0;
            buf_valid <= 1'b0;
            pf_pend   <= 1'b0;
            hit_q     <= 1'b0;
`endif
        end else begin
            ACK <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_demand) begin
                        ROM_ADDR <= REQ_ADDR;
                        ROM_nOE  <= 1'b0;
                        BUSY     <= 1'b1;
                        state    <= ST_ACCESS;
`ifdef SPROM_PREFETCH_EN
                        buf_valid <= 1'b0;
                        pf_pend   <= 1'b0;
                    end else if (hit) begin
                        // ROM_ADDR tracks the served address so the next prefetch follows it.
                        ROM_ADDR <= REQ_ADDR;
                        BUSY     <= 1'b1;
                        hit_q    <= 1'b1;
                        pf_pend  <= 1'b0;
                        state    <= ST_SAMPLE;
                    end else if (start_pf) begin
                        ROM_ADDR <= ROM_ADDR + ADDR_W'(1);
                        ROM_nOE  <= 1'b0;
                        BUSY     <= 1'b1;
                        pf_pend  <= 1'b0;
                        state    <= ST_PREFETCH;
`endif
                    end
                end
                ST_ACCESS: begin
                    if (ctr_zero) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
`ifdef SPROM_PREFETCH_EN
                    DATA    <= hit_q ? buf_data : ROM_DATA;
                    hit_q   <= 1'b0;
                    pf_pend <= 1'b1;
`else
                    DATA    <= ROM_DATA;
`endif
                    ACK     <= 1'b1;
                    ROM_nOE <= 1'b1;
                    BUSY    <= 1'b0;
                    state   <= ST_IDLE;
                end
`ifdef SPROM_PREFETCH_EN
                ST_PREFETCH: begin
                    if (ctr_zero) begin
                        buf_data  <= ROM_DATA;
                        buf_addr  <= ROM_ADDR;
                        buf_valid <= 1'b1;
                        ROM_nOE   <= 1'b1;
                        BUSY      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    ROM_nOE <= 1'b1;
                    BUSY    <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprom_reader.sv
// tb/tb_sprom_reader.sv - randomized self-checking bench with timed ROM model and transaction-level reference
module tb_sprom_reader;

    localparam int AC = 3;
    localparam int AW = 17;

    logic          CLK = 1'b0;
    logic          nRESET = 1'b0;
    logic          REQ = 1'b0;
    logic [AW-1:0] REQ_ADDR = '0;
    logic          ACK;
    logic [15:0]   DATA;
    logic          BUSY;
    logic [AW-1:0] ROM_ADDR;
    logic          ROM_nOE;
    logic [15:0]   ROM_DATA = 16'hDEAD;

    int total = 0;
    int bad = 0;

    always #21 CLK = ~CLK;

    sprom_reader #(.ACCESS_CYCLES(AC), .ADDR_W(AW)) dut (
        .CLK      (CLK),
        .nRESET   (nRESET),
        .REQ      (REQ),
        .REQ_ADDR (REQ_ADDR),
        .ACK      (ACK),
        .DATA     (DATA),
        .BUSY     (BUSY),
        .ROM_ADDR (ROM_ADDR),
        .ROM_nOE  (ROM_nOE),
        .ROM_DATA (ROM_DATA)
    );

    function automatic logic [15:0] img(input logic [AW-1:0] a);
        logic [31:0] h;
        if (a == 17'h00100) return 16'hA5C3;
        h = {15'd0, a} * 32'h9E3779B1;
        return h[31:16] ^ a[15:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Asynchronous ROM: 120 time units after address/enable settle the word appears;
    // any other time the bus carries garbage the reader must never capture.
    time           t_chg = 0;
    logic [AW-1:0] seen_addr = '0;
    logic          seen_noe = 1'b1;
    initial forever begin
        #1;
        if (ROM_ADDR !== seen_addr || ROM_nOE !== seen_noe) begin
            seen_addr = ROM_ADDR;
            seen_noe  = ROM_nOE;
            t_chg     = $time;
        end
        if (!ROM_nOE && ($time - t_chg) >= 120) ROM_DATA = img(ROM_ADDR);
        else if (ROM_nOE && ($time - t_chg) >= 50) ROM_DATA = 16'hFFFF;
        else ROM_DATA = 16'hDEAD;
    end

    logic          check_en = 1'b0;
    logic [AW-1:0] exp_addr = '0;

`ifndef SPROM_PREFETCH_EN
    // Reference: one outstanding transaction, answered AC+1 edges after it is taken.
    logic          m_busy = 1'b0;
    logic          m_ack = 1'b0;
    int            m_left = 0;
    logic [AW-1:0] m_addr = '0;
    logic [15:0]   m_data = '0;
    initial forever begin
        @(posedge CLK);
        if (!nRESET) begin
            m_busy = 1'b0; m_ack = 1'b0; m_left = 0; m_addr = '0; m_data = '0;
        end else begin
            automatic logic was_ack = m_ack;
            m_ack = 1'b0;
            if (m_busy) begin
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_ack  = 1'b1;
                    m_data = img(m_addr);
                end else begin
                    m_left--;
                end
            end else if (!was_ack && REQ) begin
                m_busy = 1'b1;
                m_addr = REQ_ADDR;
                m_left = AC;
            end
        end
    end
`endif

    initial forever begin
        @(negedge CLK);
        if (check_en) begin
`ifndef SPROM_PREFETCH_EN
            chk("ack", ACK, m_ack);
            chk("busy", BUSY, m_busy);
            chk("rom_noe", ROM_nOE, !m_busy);
            chk("rom_addr", ROM_ADDR, m_addr);
            chk("data", DATA, m_data);
`else
            if (ACK) chk("ack_data", DATA, img(exp_addr));
`endif
        end
    end

    int lat, acks, noe_low;

    task automatic do_read(input logic [AW-1:0] a, input bit hold, input bit wiggle);
        @(negedge CLK);
        REQ = 1'b1;
        REQ_ADDR = a;
        exp_addr = a;
        lat = 0; acks = 0; noe_low = 0;
        do begin
            @(negedge CLK);
            lat++;
            if (!ROM_nOE) noe_low++;
            if (wiggle && lat == 2) REQ_ADDR = AW'($urandom);
        end while (!ACK && lat < 60);
        chk("ack_seen", ACK, 1);
        if (ACK) acks++;
        if (hold) begin
            @(negedge CLK);
            if (ACK) acks++;
        end
        REQ = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            if (ACK) acks++;
        end
        chk("one_ack", acks, 1);
    endtask

    initial begin
        int stray;
        repeat (3) @(negedge CLK);
        check_en = 1'b1;
        chk("rst_ack", ACK, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_noe", ROM_nOE, 1);
        chk("rst_addr", ROM_ADDR, 0);
        chk("rst_data", DATA, 16'h0000);
        nRESET = 1'b1;

        do_read(17'h00100, 0, 0);
        chk("first_lat", lat, 5);
        chk("first_noe_cycles", noe_low, 4);
        chk("first_data", DATA, 16'hA5C3);
        chk("first_noe_after", ROM_nOE, 1);

        // reset at edge k+2 of an access
        @(negedge CLK);
        REQ = 1'b1; REQ_ADDR = 17'h01234;
        @(negedge CLK);
        @(negedge CLK);
        nRESET = 1'b0; REQ = 1'b0;
        @(negedge CLK);
        chk("midrst_ack", ACK, 0);
        chk("midrst_noe", ROM_nOE, 1);
        chk("midrst_busy", BUSY, 0);
        nRESET = 1'b1;
        stray = 0;
        repeat (8) begin
            @(negedge CLK);
            if (ACK) stray++;
        end
        chk("midrst_no_ack", stray, 0);
        do_read(17'h00004, 0, 0);
        chk("after_rst_data", DATA, img(17'h00004));

        for (int i = 0; i < 256; i++) begin
            do_read(AW'(17'h1FF80 + i), 1'($urandom_range(0, 1)), 1'b0);
        end

        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            do_read(AW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        do_read(17'h00ABC, 1, 1);
        chk("held_wiggle_data", DATA, img(17'h00ABC));

`ifdef SPROM_PREFETCH_EN
        repeat (12) @(negedge CLK);
        do_read(17'h1FFFF, 0, 0);
        chk("pf_miss_lat", lat, 5);
        repeat (12) @(negedge CLK);
        do_read(17'h00000, 0, 0);
        chk("pf_wrap_hit_lat", lat, 2);
        chk("pf_wrap_hit_data", DATA, img(17'h00000));
        repeat (12) @(negedge CLK);
        do_read(17'h00050, 0, 0);
        chk("pf_miss2_lat", lat, 5);
        chk("pf_miss2_data", DATA, img(17'h00050));
        do_read(17'h00200, 0, 0);
        do_read(17'h00201, 0, 0);
        chk("pf_during_data", DATA, img(17'h00201));
        chk("pf_during_waited", lat > 2, 1);
`endif

        repeat (4) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
